program_loader: RTL and testbench

Streams a program into the CPU's 32-entry instruction store before execution. It receives bytes over a valid/ready handshake and assembles byte pairs into 16-bit instructions. It drives the program-memory write port and holds the CPU core in reset while loading. It sits directly upstream of the program counter / program memory / decoder path.

---
 rtl/loader_pkg.sv | 27 ++
 rtl/program_loader_assembler.sv | 46 ++++
 rtl/program_loader.sv | 147 ++++++++++++++
 tb/tb_program_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: types and constants shared by the program loader and the CPU top.
//   INSTR_WIDTH / PC_VALUE_WIDTH / BYTE_WIDTH : datapath widths shared with the CPU top
//   LEN_WIDTH       : width of the load_length request (covers 0..63)
//   MAX_PROGRAM_LEN : size of the instruction store
//   loader_state_t  : loader FSM states
//   length_legal()  : true when a requested length fits the instruction store
package loader_pkg;

    localparam int INSTR_WIDTH     = 16;
    localparam int PC_VALUE_WIDTH  = 5;
    localparam int BYTE_WIDTH      = 8;
    localparam int LEN_WIDTH       = 6;
    localparam int MAX_PROGRAM_LEN = 32;

    typedef enum logic [2:0] {
        IDLE,
        RX_HI,
        RX_LO,
        WRITE,
        DONE
    } loader_state_t;

    function automatic logic length_legal(input logic [LEN_WIDTH-1:0] len);
        return (len != '0) && (len <= LEN_WIDTH'(MAX_PROGRAM_LEN));
    endfunction

endpackage

// File: rtl/program_loader_assembler.sv
// instruction_assembler: builds a 16-bit instruction from two stream bytes and
// keeps a running XOR over every accepted byte.
//   clk, rst     : clock, asynchronous active-low reset
//   clear        : zero the checksum and byte registers (start of a new load)
//   accept       : a byte is consumed this cycle
//   sel_lo       : 1 = byte is bits [7:0], 0 = byte is bits [15:8]
//   byte_data    : stream byte
//   word         : assembled instruction {hi, lo}
//   checksum     : XOR of bytes accepted since the last clear
module instruction_assembler
    import loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   accept,
    input  logic                   sel_lo,
    input  logic [BYTE_WIDTH-1:0]  byte_data,
    output logic [INSTR_WIDTH-1:0] word,
    output logic [BYTE_WIDTH-1:0]  checksum
);

    logic [BYTE_WIDTH-1:0] hi_q;
    logic [BYTE_WIDTH-1:0] lo_q;
    logic [BYTE_WIDTH-1:0] ck_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
            ck_q <= '0;
        end else if (clear) begin
            hi_q <= '0;
            lo_q <= '0;
            ck_q <= '0;
        end else if (accept) begin
            if (sel_lo) lo_q <= byte_data;
            else        hi_q <= byte_data;
            ck_q <= ck_q ^ byte_data;
        end
    end

    assign word     = {hi_q, lo_q};
    assign checksum = ck_q;

endmodule

// File: rtl/program_loader.sv
// program_loader: streams bytes into the CPU instruction store while holding
// the core in reset.
//   clk, rst                : clock, asynchronous active-low reset
//   load_start, load_length : start request and instruction count (1..32)
//   abort                   : cancel a load in progress
//   byte_valid, byte_data   : byte stream in, byte_ready : byte accepted this cycle
//   pm_we, pm_addr, pm_wdata: program-memory write port
//   cpu_hold, busy          : core held in reset / load in progress
//   done, error             : one-cycle completion / failure pulses
//   checksum                : XOR of bytes accepted in the current or last load
//
// state | meaning
// IDLE  | waiting for load_start, core released
// RX_HI | waiting for high byte of next instruction
// RX_LO | waiting for low byte
// WRITE | one-cycle program-memory write
// DONE  | one-cycle completion pulse, core still held
module program_loader
    import loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic [LEN_WIDTH-1:0]      load_length,
    input  logic                      abort,
    input  logic                      byte_valid,
    input  logic [BYTE_WIDTH-1:0]     byte_data,
    output logic                      byte_ready,
    output logic                      pm_we,
    output logic [PC_VALUE_WIDTH-1:0] pm_addr,
    output logic [INSTR_WIDTH-1:0]    pm_wdata,
    output logic                      cpu_hold,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [BYTE_WIDTH-1:0]     checksum
);

    loader_state_t             state_q, state_d;
    logic [PC_VALUE_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic                      error_q;

    logic accept, sel_lo, clear, addr_inc, start_ok, error_set;
    logic last_word;

    assign last_word = (LEN_WIDTH'(addr_q) == (len_q - LEN_WIDTH'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_set;
            if (start_ok) begin
                len_q  <= load_length;
                addr_q <= '0;
            end else if (addr_inc) begin
                addr_q <= addr_q + PC_VALUE_WIDTH'(1);
            end
        end
    end

    // abort wins over a same-cycle accept or write, so it gates both
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        sel_lo     = 1'b0;
        clear      = 1'b0;
        addr_inc   = 1'b0;
        start_ok   = 1'b0;
        error_set  = 1'b0;
        byte_ready = 1'b0;
        pm_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (length_legal(load_length)) begin
                        start_ok = 1'b1;
                        clear    = 1'b1;
                        state_d  = RX_HI;
                    end else begin
                        error_set = 1'b1;
                    end
                end
            end
            RX_HI: begin
                byte_ready = 1'b1;
                if (abort) begin
                    error_set = 1'b1;
                    state_d   = IDLE;
                end else if (byte_valid) begin
                    accept  = 1'b1;
                    state_d = RX_LO;
                end
            end
            RX_LO: begin
                byte_ready = 1'b1;
                sel_lo     = 1'b1;
                if (abort) begin
                    error_set = 1'b1;
                    state_d   = IDLE;
                end else if (byte_valid) begin
                    accept  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    error_set = 1'b1;
                    state_d   = IDLE;
                end else begin
                    pm_we = 1'b1;
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        addr_inc = 1'b1;
                        state_d  = RX_HI;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    instruction_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .accept    (accept),
        .sel_lo    (sel_lo),
        .byte_data (byte_data),
        .word      (pm_wdata),
        .checksum  (checksum)
    );

    assign pm_addr  = addr_q;
    assign busy     = (state_q != IDLE);
    assign cpu_hold = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign error    = error_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    import loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0;
    logic [5:0]  load_length = '0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, pm_we, cpu_hold, busy, done, error;
    logic [4:0]  pm_addr;
    logic [15:0] pm_wdata;
    logic [7:0]  checksum;

    int checks = 0;
    int errors = 0;

    program_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_length (load_length),
        .abort       (abort),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .pm_we       (pm_we),
        .pm_addr     (pm_addr),
        .pm_wdata    (pm_wdata),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic put(input logic v, input logic [7:0] d);
        byte_valid = v;
        byte_data  = d;
    endtask

    task automatic start(input logic [5:0] len);
        load_start  = 1'b1;
        load_length = len;
        tick();
        load_start  = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_ck;
        logic [7:0] hi_b, lo_b;

        // ---------------- reset state
        #2;
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_pm_we",      pm_we, 0);
        chk("rst_cpu_hold",   cpu_hold, 0);
        chk("rst_checksum",   checksum, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // ---------------- nominal load, length 2
        start(6'd2);
        chk("nom_busy",       busy, 1);
        chk("nom_cpu_hold",   cpu_hold, 1);
        chk("nom_byte_ready", byte_ready, 1);
        put(1, 8'h12); tick();
        put(1, 8'h34); tick();
        chk("nom_we0",    pm_we, 1);
        chk("nom_addr0",  pm_addr, 0);
        chk("nom_data0",  pm_wdata, 16'h1234);
        chk("nom_rdy_wr", byte_ready, 0);
        put(1, 8'hAB); tick();
        chk("nom_we_gap", pm_we, 0);
        tick();
        put(1, 8'hCD); tick();
        chk("nom_we1",   pm_we, 1);
        chk("nom_addr1", pm_addr, 1);
        chk("nom_data1", pm_wdata, 16'hABCD);
        put(0, 8'h00); tick();
        chk("nom_done",     done, 1);
        chk("nom_done_we",  pm_we, 0);
        chk("nom_done_err", error, 0);
        chk("nom_done_hold", cpu_hold, 1);
        chk("nom_checksum", checksum, 8'h40);
        tick();
        chk("nom_hold_low", cpu_hold, 0);
        chk("nom_done_low", done, 0);
        chk("nom_busy_low", busy, 0);

        // ---------------- stalled stream, length 1
        start(6'd1);
        put(0, 8'h55); tick();
        chk("stl_ready_hi", byte_ready, 1);
        chk("stl_we_a", pm_we, 0);
        put(1, 8'h55); tick();
        put(0, 8'h66); tick();
        chk("stl_ready_lo", byte_ready, 1);
        chk("stl_we_b", pm_we, 0);
        put(1, 8'h66); tick();
        chk("stl_we",   pm_we, 1);
        chk("stl_addr", pm_addr, 0);
        chk("stl_data", pm_wdata, 16'h5566);
        put(0, 8'h00); tick();
        chk("stl_we_once", pm_we, 0);
        chk("stl_done",    done, 1);
        chk("stl_checksum", checksum, 8'h33);
        tick();

        // ---------------- illegal lengths
        start(6'd0);
        chk("ill0_error", error, 1);
        chk("ill0_busy",  busy, 0);
        chk("ill0_hold",  cpu_hold, 0);
        chk("ill0_we",    pm_we, 0);
        tick();
        chk("ill0_pulse", error, 0);
        start(6'd33);
        chk("ill33_error", error, 1);
        chk("ill33_busy",  busy, 0);
        chk("ill33_hold",  cpu_hold, 0);
        chk("ill33_rdy",   byte_ready, 0);
        tick();
        chk("ill33_pulse", error, 0);

        // ---------------- full program, length 32
        start(6'd32);
        exp_ck = 8'h00;
        for (int i = 0; i < 32; i++) begin
            hi_b = 8'(i);
            lo_b = 8'(8'hC3 ^ (i * 5));
            exp_ck = exp_ck ^ hi_b ^ lo_b;
            put(1, hi_b); tick();
            put(1, lo_b); tick();
            chk("full_we",   pm_we, 1);
            chk("full_addr", pm_addr, i);
            chk("full_data", pm_wdata, {hi_b, lo_b});
            put(0, 8'h00); tick();
            if (i < 31) chk("full_next_rdy", byte_ready, 1);
        end
        chk("full_done",      done, 1);
        chk("full_no_wrap",   pm_we, 0);
        chk("full_addr_last", pm_addr, 31);
        chk("full_checksum",  checksum, exp_ck);
        tick();
        chk("full_hold_low", cpu_hold, 0);

        // ---------------- abort on LO byte of instruction 3
        start(6'd4);
        put(1, 8'h01); tick();
        put(1, 8'h02); tick();
        chk("abt_we0", pm_data_ok(16'h0102), 1);
        put(0, 8'h00); tick();
        load_start = 1'b1; load_length = 6'd5;
        put(1, 8'h03); tick();
        load_start = 1'b0;
        put(1, 8'h04); tick();
        chk("abt_we1", pm_data_ok(16'h0304), 1);
        chk("abt_addr1", pm_addr, 1);
        put(0, 8'h00); tick();
        put(1, 8'h05); tick();
        put(1, 8'h06); abort = 1'b1;
        #1;
        chk("abt_pre_we", pm_we, 0);
        tick();
        abort = 1'b0; put(0, 8'h00);
        chk("abt_error",   error, 1);
        chk("abt_done",    done, 0);
        chk("abt_we2",     pm_we, 0);
        chk("abt_busy",    busy, 0);
        chk("abt_hold",    cpu_hold, 0);
        chk("abt_checksum", checksum, 8'h01);
        tick();
        chk("abt_err_pulse", error, 0);
        chk("abt_ignored_start", busy, 0);
        chk("abt_rdy", byte_ready, 0);

        // ---------------- async reset mid-WRITE
        start(6'd2);
        put(1, 8'hE1); tick();
        put(1, 8'hE2); tick();
        chk("ar_we_before", pm_we, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_we",       pm_we, 0);
        chk("ar_addr",     pm_addr, 0);
        chk("ar_wdata",    pm_wdata, 0);
        chk("ar_hold",     cpu_hold, 0);
        chk("ar_busy",     busy, 0);
        chk("ar_ready",    byte_ready, 0);
        chk("ar_checksum", checksum, 0);
        chk("ar_done_err", {done, error}, 0);
        put(0, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        start(6'd1);
        put(1, 8'h9A); tick();
        put(1, 8'hBC); tick();
        chk("ar2_we",   pm_we, 1);
        chk("ar2_addr", pm_addr, 0);
        chk("ar2_data", pm_wdata, 16'h9ABC);
        put(0, 8'h00); tick();
        chk("ar2_done",     done, 1);
        chk("ar2_checksum", checksum, 8'h26);
        tick();
        chk("ar2_hold_low", cpu_hold, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic pm_data_ok(input logic [15:0] w);
        return pm_we && (pm_wdata == w);
    endfunction

endmodule
